pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register for the 5-stage core. It is the generalised successor to the fixed ID/EX latch and is instantiable at any stage boundary. It carries an opaque data bundle and a control bundle through a valid/ready interface, with synchronous flush to a bubble and backpressure instead of a free-running latch. An optional skid slot registers `in_ready` to cut the combinational ready path, and saturating counters track bubbles and flushes for performance debug.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_cnt_sat.sv | 32 +++
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage register:
// occupancy states and the default ID/EX control and data bundle layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // Default control bundle bit positions (ID/EX)
    localparam int PIPE_CTRL_W        = 11;
    localparam int CTRL_ALUSRC        = 0;
    localparam int CTRL_BRANCH        = 1;
    localparam int CTRL_JUMP          = 2;
    localparam int CTRL_ALUCTL_LO     = 3;
    localparam int CTRL_ALUCTL_HI     = 5;
    localparam int CTRL_MEMRD         = 6;
    localparam int CTRL_MEMWR         = 7;
    localparam int CTRL_REGWR         = 8;
    localparam int CTRL_RESSRC_LO     = 9;
    localparam int CTRL_RESSRC_HI     = 10;

    localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_BUBBLE = '0;

    // Default data bundle field offsets (ID/EX): Rs2, Rs1, Rd, Imm, RD2, RD1, PC+4, PC
    localparam int PIPE_DATA_W        = 175;
    localparam int DATA_RS2_LO        = 0;
    localparam int DATA_RS1_LO        = 5;
    localparam int DATA_RD_LO         = 10;
    localparam int DATA_IMM_LO        = 15;
    localparam int DATA_RD2_LO        = 47;
    localparam int DATA_RD1_LO        = 79;
    localparam int DATA_PC4_LO        = 111;
    localparam int DATA_PC_LO         = 143;

endpackage

// File: rtl/pipe_cnt_sat.sv
// Saturating up-counter used for the stage's performance-debug counters.
// Counts one per cycle while inc is high and sticks at all-ones.
module pipe_cnt_sat #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional skid slot, synchronous
// flush to a bubble, and saturating bubble/flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = PIPE_DATA_W,
    parameter int                CTRL_W      = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(PIPE_CTRL_BUBBLE),
    parameter bit                SKID        = 1'b1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] mData_q, mData_d;
    logic [CTRL_W-1:0] mCtrl_q, mCtrl_d;
    logic [DATA_W-1:0] sData_q, sData_d;
    logic [CTRL_W-1:0] sCtrl_q, sCtrl_d;

    logic accept;
    logic drain;
    logic bubbleInc;
    logic flushInc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
            mData_q <= '0;
            mCtrl_q <= CTRL_BUBBLE;
            sData_q <= '0;
            sCtrl_q <= CTRL_BUBBLE;
        end else begin
            state_q <= state_d;
            mData_q <= mData_d;
            mCtrl_q <= mCtrl_d;
            sData_q <= sData_d;
            sCtrl_q <= sCtrl_d;
        end
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // Emptied slots are rewritten as bubbles so out_* reads as a NOP when idle.
    always_comb begin
        state_d = state_q;
        mData_d = mData_q;
        mCtrl_d = mCtrl_q;
        sData_d = sData_q;
        sCtrl_d = sCtrl_q;
        if (flush) begin
            state_d = EMPTY;
            mData_d = '0;
            mCtrl_d = CTRL_BUBBLE;
            sData_d = '0;
            sCtrl_d = CTRL_BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        mData_d = in_data;
                        mCtrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        mData_d = in_data;
                        mCtrl_d = in_ctrl;
                    end else if (accept && SKID) begin
                        state_d = TWO;
                        sData_d = in_data;
                        sCtrl_d = in_ctrl;
                    end else if (drain) begin
                        state_d = EMPTY;
                        mData_d = '0;
                        mCtrl_d = CTRL_BUBBLE;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_d = ONE;
                        mData_d = sData_q;
                        mCtrl_d = sCtrl_q;
                        sData_d = '0;
                        sCtrl_d = CTRL_BUBBLE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = mData_q;
        out_ctrl  = mCtrl_q;
        if (SKID) begin
            in_ready = (state_q != TWO);
        end else begin
            in_ready = (state_q == EMPTY) || out_ready;
        end
    end

    assign bubbleInc = out_ready && !out_valid;
    assign flushInc  = flush && (state_q != EMPTY);

    pipe_cnt_sat #(.W(CNT_W)) uBubbleCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubbleInc),
        .cnt   (bubble_cnt)
    );

    pipe_cnt_sat #(.W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flushInc),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: default skid stage, a
// SKID=0 stage and a narrow-counter stage all driven from the same inputs.
module tb_pipe_stage_reg;

    localparam int DW = 175;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          inValid;
    logic          outReady;
    logic [DW-1:0] inData;
    logic [CW-1:0] inCtrl;

    logic          inReady, outValid;
    logic [DW-1:0] outData;
    logic [CW-1:0] outCtrl;
    logic [15:0]   bubbleCnt, flushCnt;

    logic          inReady0, outValid0;
    logic [DW-1:0] outData0;
    logic [CW-1:0] outCtrl0;
    logic [15:0]   bubbleCnt0, flushCnt0;

    logic          inReady2, outValid2;
    logic [DW-1:0] outData2;
    logic [CW-1:0] outCtrl2;
    logic [1:0]    bubbleCnt2, flushCnt2;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg uDut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_data(inData), .in_ctrl(inCtrl),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_ctrl(outCtrl),
        .bubble_cnt(bubbleCnt), .flush_cnt(flushCnt)
    );

    pipe_stage_reg #(.SKID(1'b0)) uDut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady0), .in_data(inData), .in_ctrl(inCtrl),
        .out_valid(outValid0), .out_ready(outReady), .out_data(outData0), .out_ctrl(outCtrl0),
        .bubble_cnt(bubbleCnt0), .flush_cnt(flushCnt0)
    );

    pipe_stage_reg #(.CNT_W(2)) uDut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady2), .in_data(inData), .in_ctrl(inCtrl),
        .out_valid(outValid2), .out_ready(outReady), .out_data(outData2), .out_ctrl(outCtrl2),
        .bubble_cnt(bubbleCnt2), .flush_cnt(flushCnt2)
    );

    function automatic logic [DW-1:0] mkData(input logic [7:0] t);
        return {t, 159'd0, t};
    endfunction

    function automatic logic [CW-1:0] mkCtrl(input logic [7:0] t);
        return {3'b000, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] t);
        inValid = v;
        inData  = mkData(t);
        inCtrl  = mkCtrl(t);
    endtask

    task automatic doReset();
        reset = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inData = '0; inCtrl = '0;
        tick();
        reset = 1'b1;
        #1;
        nChecks++; if (outValid !== 1'b0) begin nFail++; $display("[TB] FAIL por_out_valid: got %0b expected 0", outValid); end
        nChecks++; if (inReady !== 1'b1) begin nFail++; $display("[TB] FAIL por_in_ready: got %0b expected 1", inReady); end
        nChecks++; if (outCtrl !== 11'h000) begin nFail++; $display("[TB] FAIL por_out_ctrl: got %h expected 000", outCtrl); end
        nChecks++; if (outData !== '0) begin nFail++; $display("[TB] FAIL por_out_data: got %h expected 0", outData); end
        nChecks++; if (bubbleCnt !== 16'd0 || flushCnt !== 16'd0) begin nFail++; $display("[TB] FAIL por_counters: got %0d/%0d expected 0/0", bubbleCnt, flushCnt); end
        drive(1'b1, 8'hA1); tick();
        drive(1'b1, 8'hB2); tick();
        nChecks++; if (inReady !== 1'b0) begin nFail++; $display("[TB] FAIL two_in_ready: got %0b expected 0", inReady); end
        inCtrl = 11'h7FF; inData = mkData(8'hFF);
        reset = 1'b0;
        tick();
        reset = 1'b1; inValid = 1'b0;
        #1;
        nChecks++; if (outValid !== 1'b0) begin nFail++; $display("[TB] FAIL rst_two_out_valid: got %0b expected 0", outValid); end
        nChecks++; if (outCtrl !== 11'h000) begin nFail++; $display("[TB] FAIL rst_two_out_ctrl: got %h expected 000", outCtrl); end
        nChecks++; if (outData !== '0) begin nFail++; $display("[TB] FAIL rst_two_out_data: got %h expected 0", outData); end
        nChecks++; if (inReady !== 1'b1) begin nFail++; $display("[TB] FAIL rst_two_in_ready: got %0b expected 1", inReady); end
        nChecks++; if (bubbleCnt !== 16'd0 || flushCnt !== 16'd0) begin nFail++; $display("[TB] FAIL rst_two_counters: got %0d/%0d expected 0/0", bubbleCnt, flushCnt); end
    endtask

    task automatic test_stream();
        doReset();
        drive(1'b1, 8'h11); outReady = 1'b0;
        tick();
        nChecks++; if (outValid !== 1'b1 || outCtrl !== mkCtrl(8'h11) || outData !== mkData(8'h11)) begin nFail++; $display("[TB] FAIL stream_a: got v=%0b ctrl=%h expected v=1 ctrl=%h", outValid, outCtrl, mkCtrl(8'h11)); end
        drive(1'b1, 8'h22); outReady = 1'b1;
        tick();
        nChecks++; if (outValid !== 1'b1 || outCtrl !== mkCtrl(8'h22) || outData !== mkData(8'h22)) begin nFail++; $display("[TB] FAIL stream_b: got v=%0b ctrl=%h expected v=1 ctrl=%h", outValid, outCtrl, mkCtrl(8'h22)); end
        drive(1'b1, 8'h33);
        #1;
        nChecks++; if (inReady !== 1'b1) begin nFail++; $display("[TB] FAIL stream_in_ready: got %0b expected 1", inReady); end
        tick();
        nChecks++; if (outValid !== 1'b1 || outCtrl !== mkCtrl(8'h33) || outData !== mkData(8'h33)) begin nFail++; $display("[TB] FAIL stream_c: got v=%0b ctrl=%h expected v=1 ctrl=%h", outValid, outCtrl, mkCtrl(8'h33)); end
        inValid = 1'b0;
        tick();
        outReady = 1'b0;
        nChecks++; if (outValid !== 1'b0 || outCtrl !== 11'h000 || outData !== '0) begin nFail++; $display("[TB] FAIL stream_drained: got v=%0b ctrl=%h expected v=0 ctrl=000", outValid, outCtrl); end
        nChecks++; if (bubbleCnt !== 16'd0) begin nFail++; $display("[TB] FAIL stream_bubble_cnt: got %0d expected 0", bubbleCnt); end
    endtask

    task automatic test_back_to_back();
        doReset();
        drive(1'b1, 8'h41);
        tick();
        nChecks++; if (inReady !== 1'b1 || outCtrl !== mkCtrl(8'h41)) begin nFail++; $display("[TB] FAIL bp_one: got rdy=%0b ctrl=%h expected rdy=1 ctrl=%h", inReady, outCtrl, mkCtrl(8'h41)); end
        drive(1'b1, 8'h52);
        tick();
        drive(1'b1, 8'h63);
        #1;
        nChecks++; if (inReady !== 1'b0 || outValid !== 1'b1 || outCtrl !== mkCtrl(8'h41)) begin nFail++; $display("[TB] FAIL bp_two: got rdy=%0b ctrl=%h expected rdy=0 ctrl=%h", inReady, outCtrl, mkCtrl(8'h41)); end
        tick();
        nChecks++; if (inReady !== 1'b0 || outCtrl !== mkCtrl(8'h41)) begin nFail++; $display("[TB] FAIL bp_hold: got rdy=%0b ctrl=%h expected rdy=0 ctrl=%h", inReady, outCtrl, mkCtrl(8'h41)); end
        inValid = 1'b0; outReady = 1'b1;
        tick();
        nChecks++; if (outValid !== 1'b1 || outCtrl !== mkCtrl(8'h52) || outData !== mkData(8'h52)) begin nFail++; $display("[TB] FAIL bp_drain_b: got v=%0b ctrl=%h expected v=1 ctrl=%h", outValid, outCtrl, mkCtrl(8'h52)); end
        nChecks++; if (inReady !== 1'b1) begin nFail++; $display("[TB] FAIL bp_ready_back: got %0b expected 1", inReady); end
        tick();
        outReady = 1'b0;
        nChecks++; if (outValid !== 1'b0 || outCtrl !== 11'h000) begin nFail++; $display("[TB] FAIL bp_empty: got v=%0b ctrl=%h expected v=0 ctrl=000", outValid, outCtrl); end
        nChecks++; if (bubbleCnt !== 16'd0) begin nFail++; $display("[TB] FAIL bp_bubble_cnt: got %0d expected 0", bubbleCnt); end
    endtask

    task automatic test_flush();
        doReset();
        drive(1'b1, 8'h71); tick();
        drive(1'b1, 8'h72); tick();
        flush = 1'b1; outReady = 1'b1; drive(1'b1, 8'h73);
        tick();
        flush = 1'b0; outReady = 1'b0; inValid = 1'b0;
        #1;
        nChecks++; if (outValid !== 1'b0 || outCtrl !== 11'h000 || outData !== '0) begin nFail++; $display("[TB] FAIL flush_two: got v=%0b ctrl=%h expected v=0 ctrl=000", outValid, outCtrl); end
        nChecks++; if (inReady !== 1'b1) begin nFail++; $display("[TB] FAIL flush_in_ready: got %0b expected 1", inReady); end
        nChecks++; if (flushCnt !== 16'd1) begin nFail++; $display("[TB] FAIL flush_cnt_two: got %0d expected 1", flushCnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nChecks++; if (flushCnt !== 16'd1) begin nFail++; $display("[TB] FAIL flush_cnt_empty: got %0d expected 1", flushCnt); end
        drive(1'b1, 8'h74); tick();
        flush = 1'b1; outReady = 1'b1; drive(1'b1, 8'h75);
        tick();
        flush = 1'b0; outReady = 1'b0; inValid = 1'b0;
        nChecks++; if (outValid !== 1'b0 || outCtrl !== 11'h000) begin nFail++; $display("[TB] FAIL flush_one: got v=%0b ctrl=%h expected v=0 ctrl=000", outValid, outCtrl); end
        nChecks++; if (flushCnt !== 16'd2) begin nFail++; $display("[TB] FAIL flush_cnt_one: got %0d expected 2", flushCnt); end
    endtask

    task automatic test_noskid();
        doReset();
        drive(1'b1, 8'h81);
        tick();
        drive(1'b1, 8'h93);
        #1;
        nChecks++; if (inReady0 !== 1'b0 || outCtrl0 !== mkCtrl(8'h81)) begin nFail++; $display("[TB] FAIL noskid_stall: got rdy=%0b ctrl=%h expected rdy=0 ctrl=%h", inReady0, outCtrl0, mkCtrl(8'h81)); end
        tick();
        nChecks++; if (outValid0 !== 1'b1 || outCtrl0 !== mkCtrl(8'h81)) begin nFail++; $display("[TB] FAIL noskid_hold: got v=%0b ctrl=%h expected v=1 ctrl=%h", outValid0, outCtrl0, mkCtrl(8'h81)); end
        outReady = 1'b1;
        #1;
        nChecks++; if (inReady0 !== 1'b1) begin nFail++; $display("[TB] FAIL noskid_ready_comb: got %0b expected 1", inReady0); end
        tick();
        nChecks++; if (outValid0 !== 1'b1 || outCtrl0 !== mkCtrl(8'h93) || outData0 !== mkData(8'h93)) begin nFail++; $display("[TB] FAIL noskid_c: got v=%0b ctrl=%h expected v=1 ctrl=%h", outValid0, outCtrl0, mkCtrl(8'h93)); end
        inValid = 1'b0;
        tick();
        outReady = 1'b0;
        nChecks++; if (outValid0 !== 1'b0 || outCtrl0 !== 11'h000) begin nFail++; $display("[TB] FAIL noskid_empty: got v=%0b ctrl=%h expected v=0 ctrl=000", outValid0, outCtrl0); end
    endtask

    task automatic test_bubble_sat();
        logic [1:0] expSeq [6];
        expSeq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        doReset();
        outReady = 1'b1; inValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            nChecks++; if (bubbleCnt2 !== expSeq[i]) begin nFail++; $display("[TB] FAIL bubble_sat_%0d: got %0d expected %0d", i, bubbleCnt2, expSeq[i]); end
        end
        outReady = 1'b0;
        nChecks++; if (bubbleCnt !== 16'd6) begin nFail++; $display("[TB] FAIL bubble_wide: got %0d expected 6", bubbleCnt); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_flush();
        test_noskid();
        test_bubble_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
